// File: rtl/nand_seq_pkg.sv
// Shared encodings for the NAND command sequencer: host ops, item kinds,
// NAND command bytes and the sequencer state enum.
package nand_seq_pkg;

  typedef enum logic [2:0] {
    OP_READ    = 3'd0,
    OP_PROGRAM = 3'd1,
    OP_ERASE   = 3'd2,
    OP_RESET   = 3'd3,
    OP_READ_ID = 3'd4,
    OP_STATUS  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    KIND_CMD   = 2'd0,
    KIND_ADDR  = 2'd1,
    KIND_WDATA = 2'd2,
    KIND_RDATA = 2'd3
  } kind_e;

  localparam logic [7:0] CMD_READ1   = 8'h00;
  localparam logic [7:0] CMD_READ2   = 8'h30;
  localparam logic [7:0] CMD_PROG1   = 8'h80;
  localparam logic [7:0] CMD_PROG2   = 8'h10;
  localparam logic [7:0] CMD_ERASE1  = 8'h60;
  localparam logic [7:0] CMD_ERASE2  = 8'hD0;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_READ_ID = 8'h90;
  localparam logic [7:0] CMD_STATUS  = 8'h70;

  // Cycles allowed for the flash to pull nRB low before assuming a fast op.
  localparam int BSY_WINDOW = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD1,
    ST_ADDR,
    ST_DATA_W,
    ST_CMD2,
    ST_WAIT_BSY,
    ST_WAIT_RDY,
    ST_DATA_R,
    ST_DONE
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/nand_rb_sync.sv
// Two-flop synchronizer for the flash ready/busy_n line; resets to "ready".
module nand_rb_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain behaves as two real stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/nand_cmd_seq.sv
// Host-side NAND command sequencer: expands one host request into the ordered
// cmd/address/data item stream for the bus FSM, then tracks busy/ready.
module nand_cmd_seq
  import nand_seq_pkg::*;
#(
  parameter int COL_BYTES = 2,
  parameter int ROW_BYTES = 3,
  parameter int LEN_W     = 12,
  parameter int TMO_W     = 20
) (
  input  logic                   P_clk,
  input  logic                   P_rst,
  input  logic                   H_ReqValid,
  output logic                   H_ReqReady,
  input  logic [2:0]             H_Op,
  input  logic [8*COL_BYTES-1:0] H_Col,
  input  logic [8*ROW_BYTES-1:0] H_Row,
  input  logic [LEN_W-1:0]       H_Len,
  input  logic                   H_WrValid,
  output logic                   H_WrReady,
  input  logic [7:0]             H_WrData,
  output logic                   H_Done,
  output logic                   H_Error,
  output logic                   S_Valid,
  input  logic                   S_Ready,
  output logic [1:0]             S_Kind,
  output logic [7:0]             S_Byte,
  output logic                   S_Last,
  input  logic                   F_nRB
);

  localparam int ADDR_N = COL_BYTES + ROW_BYTES;
  localparam int AW     = $clog2(ADDR_N + 1);

  state_e                   state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic [8*COL_BYTES-1:0]   col_q, col_d;
  logic [8*ROW_BYTES-1:0]   row_q, row_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     error_q, error_d;

  logic                     nrb_sync;
  logic [8*ADDR_N-1:0]      addr_all;
  logic [7:0]               addr_byte;
  logic [AW-1:0]            addr_n;
  logic [7:0]               cmd1_byte, cmd2_byte;

  nand_rb_sync u_rb_sync (
    .clk_i   (P_clk),
    .rst_i   (P_rst),
    .async_i (F_nRB),
    .sync_o  (nrb_sync)
  );

  assign addr_all = {row_q, col_q};

  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

  // Per-op command bytes, address length and address byte selection.
  always_comb begin
    cmd1_byte = CMD_STATUS;
    cmd2_byte = CMD_READ2;
    addr_n    = AW'(ADDR_N);
    addr_byte = addr_all[8*int'(idx_q) +: 8];
    case (op_q)
      OP_READ:    cmd1_byte = CMD_READ1;
      OP_PROGRAM: begin cmd1_byte = CMD_PROG1;  cmd2_byte = CMD_PROG2;  end
      OP_ERASE: begin
        cmd1_byte = CMD_ERASE1;
        cmd2_byte = CMD_ERASE2;
        addr_n    = AW'(ROW_BYTES);
        addr_byte = row_q[8*int'(idx_q) +: 8];
      end
      OP_RESET:   cmd1_byte = CMD_RESET;
      OP_READ_ID: begin
        cmd1_byte = CMD_READ_ID;
        addr_n    = AW'(1);
        addr_byte = 8'h00;
      end
      default:    cmd1_byte = CMD_STATUS;
    endcase
  end

  // NOTE: every output and next-state signal gets a default first so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    error_d   = error_q;
    S_Valid   = 1'b0;
    S_Kind    = KIND_CMD;
    S_Byte    = 8'h00;
    S_Last    = 1'b0;
    H_WrReady = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (H_ReqValid) begin
          op_d    = H_Op;
          col_d   = H_Col;
          row_d   = H_Row;
          cnt_d   = (H_Op == OP_STATUS) ? LEN_W'(1) : H_Len;
          idx_d   = '0;
          tmo_d   = '0;
          error_d = !op_legal(H_Op);
          state_d = op_legal(H_Op) ? ST_CMD1 : ST_DONE;
        end
      end
      ST_CMD1: begin
        S_Valid = 1'b1;
        S_Byte  = cmd1_byte;
        S_Last  = (op_q == OP_RESET);
        if (S_Ready) begin
          case (op_q)
            OP_RESET:  state_d = ST_WAIT_BSY;
            OP_STATUS: state_d = ST_DATA_R;
            default:   state_d = ST_ADDR;
          endcase
        end
      end
      ST_ADDR: begin
        S_Valid = 1'b1;
        S_Kind  = KIND_ADDR;
        S_Byte  = addr_byte;
        S_Last  = (op_q == OP_READ_ID) && (cnt_q == '0);
        if (S_Ready) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == addr_n - 1'b1) begin
            case (op_q)
              OP_PROGRAM: state_d = (cnt_q == '0) ? ST_CMD2 : ST_DATA_W;
              OP_READ_ID: state_d = (cnt_q == '0) ? ST_DONE : ST_DATA_R;
              default:    state_d = ST_CMD2;
            endcase
          end
        end
      end
      ST_DATA_W: begin
        S_Valid   = H_WrValid;
        S_Kind    = KIND_WDATA;
        S_Byte    = H_WrData;
        H_WrReady = S_Ready;
        if (H_WrValid && S_Ready) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = ST_CMD2;
        end
      end
      ST_CMD2: begin
        S_Valid = 1'b1;
        S_Byte  = cmd2_byte;
        // A READ with data still to come is not finished by its 30h.
        S_Last  = (op_q != OP_READ) || (cnt_q == '0);
        if (S_Ready) state_d = ST_WAIT_BSY;
      end
      ST_WAIT_BSY: begin
        tmo_d = tmo_q + 1'b1;
        if (!nrb_sync || tmo_q == TMO_W'(BSY_WINDOW - 1)) begin
          tmo_d   = '0;
          state_d = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (nrb_sync) begin
          state_d = (op_q == OP_READ && cnt_q != '0) ? ST_DATA_R : ST_DONE;
        end else if (tmo_q == '1) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DATA_R: begin
        S_Valid = 1'b1;
        S_Kind  = KIND_RDATA;
        S_Last  = (cnt_q == LEN_W'(1));
        if (S_Ready) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign H_ReqReady = (state_q == ST_IDLE);
  assign H_Done     = (state_q == ST_DONE);
  assign H_Error    = (state_q == ST_DONE) && error_q;

endmodule

// File: tb/tb_nand_cmd_seq.sv
// Scoreboard bench for nand_cmd_seq: directed requests push expected items and
// completions; a monitor pops and compares on every transfer and Done pulse.
module tb_nand_cmd_seq;

  localparam int COL_BYTES = 2;
  localparam int ROW_BYTES = 3;
  localparam int LEN_W     = 12;
  localparam int TMO_W     = 6;

  logic                   P_clk = 1'b0;
  logic                   P_rst;
  logic                   H_ReqValid, H_ReqReady;
  logic [2:0]             H_Op;
  logic [8*COL_BYTES-1:0] H_Col;
  logic [8*ROW_BYTES-1:0] H_Row;
  logic [LEN_W-1:0]       H_Len;
  logic                   H_WrValid, H_WrReady;
  logic [7:0]             H_WrData;
  logic                   H_Done, H_Error;
  logic                   S_Valid, S_Ready, S_Last;
  logic [1:0]             S_Kind;
  logic [7:0]             S_Byte;
  logic                   F_nRB;

  nand_cmd_seq #(
    .COL_BYTES (COL_BYTES),
    .ROW_BYTES (ROW_BYTES),
    .LEN_W     (LEN_W),
    .TMO_W     (TMO_W)
  ) dut (
    .P_clk      (P_clk),
    .P_rst      (P_rst),
    .H_ReqValid (H_ReqValid),
    .H_ReqReady (H_ReqReady),
    .H_Op       (H_Op),
    .H_Col      (H_Col),
    .H_Row      (H_Row),
    .H_Len      (H_Len),
    .H_WrValid  (H_WrValid),
    .H_WrReady  (H_WrReady),
    .H_WrData   (H_WrData),
    .H_Done     (H_Done),
    .H_Error    (H_Error),
    .S_Valid    (S_Valid),
    .S_Ready    (S_Ready),
    .S_Kind     (S_Kind),
    .S_Byte     (S_Byte),
    .S_Last     (S_Last),
    .F_nRB      (F_nRB)
  );

  always #5 P_clk = ~P_clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] byte_v;
    logic       last;
  } item_t;

  item_t exp_q[$];
  logic  done_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cycle    = 0;
  int    done_cnt = 0;
  int    busy_req = 0;
  int    busy_ack = 0;
  int    busy_len = 10;
  int    accept_cycle = 0;
  int    last_done_cycle = 0;
  bit    stall_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] b, input logic last);
    item_t it;
    it.kind   = kind;
    it.byte_v = b;
    it.last   = last;
    exp_q.push_back(it);
  endtask

  always @(posedge P_clk) cycle++;

  // Sink ready: always 1, or random per cycle when stalls are enabled.
  initial begin
    S_Ready = 1'b1;
    forever begin
      @(posedge P_clk);
      #1 S_Ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Flash model: each busy-starting command pulls nRB low for busy_len cycles.
  initial begin
    F_nRB = 1'b1;
    forever begin
      @(posedge P_clk);
      if (busy_req > busy_ack) begin
        busy_ack = busy_req;
        #1 F_nRB = 1'b0;
        repeat (busy_len) @(posedge P_clk);
        #1 F_nRB = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  item_t held;
  bit    was_stalled = 1'b0;
  always @(negedge P_clk) begin
    item_t e;
    if (P_rst) begin
      was_stalled = 1'b0;
    end else begin
      if (was_stalled)
        check("stall_hold", {S_Valid, S_Kind, S_Byte, S_Last}, {1'b1, held.kind, held.byte_v, held.last});
      was_stalled = S_Valid && !S_Ready && (S_Kind != 2'd2);
      held = '{kind: S_Kind, byte_v: S_Byte, last: S_Last};
      if (S_Valid && S_Ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_item: got kind %0d byte %02h, none expected", S_Kind, S_Byte);
        end else begin
          e = exp_q.pop_front();
          check("item_kind", S_Kind, e.kind);
          check("item_byte", S_Byte, e.byte_v);
          check("item_last", S_Last, e.last);
        end
        if (S_Kind == 2'd0 && (S_Byte == 8'h30 || S_Byte == 8'h10 || S_Byte == 8'hD0 || S_Byte == 8'hFF))
          busy_req++;
      end
      if (H_Done) begin
        done_cnt++;
        last_done_cycle = cycle;
        check("reqready_low_in_done", H_ReqReady, 1'b0);
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got Done, none expected");
        end else begin
          check("done_error", H_Error, done_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] col, input logic [23:0] row,
                       input logic [11:0] len);
    bit ok = 1'b0;
    H_Op = op; H_Col = col; H_Row = row; H_Len = len;
    H_ReqValid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge P_clk);
      if (H_ReqReady) begin
        ok = 1'b1;
        accept_cycle = cycle;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge P_clk);
    #1 H_ReqValid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  start = done_cnt;
    bit  ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge P_clk);
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", ok, 1'b1);
    #1;
    if (ok) check("reqready_after_done", H_ReqReady, 1'b1);
    check("items_consumed", exp_q.size(), 0);
  endtask

  task automatic drive_wr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bytes [3];
    bit ok;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    for (int k = 0; k < 3; k++) begin
      H_WrData  = bytes[k];
      H_WrValid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge P_clk);
        if (H_WrReady) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check("wr_accept_timeout", 32'd0, 32'd1);
      @(posedge P_clk);
      #1 H_WrValid = 1'b0;
      if (k == 0) begin
        repeat (2) @(posedge P_clk);
        #1;
      end
    end
  endtask

  initial begin
    int saved;
    int diff;
    P_rst = 1'b1;
    H_ReqValid = 1'b0; H_Op = '0; H_Col = '0; H_Row = '0; H_Len = '0;
    H_WrValid = 1'b0; H_WrData = '0;
    repeat (3) @(posedge P_clk);
    #1;
    check("rst_s_valid", S_Valid, 1'b0);
    check("rst_s_kind", S_Kind, 2'd0);
    check("rst_s_byte", S_Byte, 8'h00);
    check("rst_s_last", S_Last, 1'b0);
    check("rst_done", H_Done, 1'b0);
    check("rst_error", H_Error, 1'b0);
    check("rst_wrready", H_WrReady, 1'b0);
    check("rst_reqready", H_ReqReady, 1'b1);
    P_rst = 1'b0;
    @(posedge P_clk); #1;

    // READ Col=0x0102 Row=0x030405 Len=4
    busy_len = 10;
    push(0, 8'h00, 0); push(1, 8'h02, 0); push(1, 8'h01, 0);
    push(1, 8'h05, 0); push(1, 8'h04, 0); push(1, 8'h03, 0); push(0, 8'h30, 0);
    push(3, 8'h00, 0); push(3, 8'h00, 0); push(3, 8'h00, 0); push(3, 8'h00, 1);
    done_q.push_back(1'b0);
    issue(3'd0, 16'h0102, 24'h030405, 12'd4);
    wait_done(200);

    // PROGRAM Len=3, data A0 (gap) A1 A2
    busy_len = 8;
    push(0, 8'h80, 0); push(1, 8'h0B, 0); push(1, 8'h0A, 0);
    push(1, 8'h0E, 0); push(1, 8'h0D, 0); push(1, 8'h0C, 0);
    push(2, 8'hA0, 0); push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(0, 8'h10, 1);
    done_q.push_back(1'b0);
    fork
      drive_wr(8'hA0, 8'hA1, 8'hA2);
    join_none
    issue(3'd1, 16'h0A0B, 24'h0C0D0E, 12'd3);
    wait_done(300);

    // ERASE with random sink stalls: row bytes only
    busy_len = 5;
    stall_mode = 1'b1;
    push(0, 8'h60, 0); push(1, 8'h33, 0); push(1, 8'h22, 0); push(1, 8'h11, 0);
    push(0, 8'hD0, 1);
    done_q.push_back(1'b0);
    issue(3'd2, 16'hFFFF, 24'h112233, 12'd0);
    wait_done(400);
    stall_mode = 1'b0;
    @(posedge P_clk); #1;

    // RESET with nRB stuck low beyond the timeout
    busy_len = 100;
    push(0, 8'hFF, 1);
    done_q.push_back(1'b1);
    issue(3'd3, 16'h0, 24'h0, 12'd0);
    wait_done(300);
    for (int i = 0; i < 200 && !F_nRB; i++) @(posedge P_clk);
    check("flash_released", F_nRB, 1'b1);
    busy_len = 10;
    repeat (3) @(posedge P_clk); #1;

    // STATUS right after the timeout
    push(0, 8'h70, 0); push(3, 8'h00, 1);
    done_q.push_back(1'b0);
    issue(3'd5, 16'h0, 24'h0, 12'd9);
    wait_done(50);

    // Illegal op: no items, Done+Error promptly
    done_q.push_back(1'b1);
    issue(3'd7, 16'h0, 24'h0, 12'd4);
    wait_done(20);
    diff = last_done_cycle - accept_cycle;
    check("illegal_done_latency", (diff >= 1 && diff <= 2), 1'b1);

    // READ_ID Len=2
    push(0, 8'h90, 0); push(1, 8'h00, 0); push(3, 8'h00, 0); push(3, 8'h00, 1);
    done_q.push_back(1'b0);
    issue(3'd4, 16'h5555, 24'h666666, 12'd2);
    wait_done(50);

    // Reset in the middle of ADDR aborts silently
    push(0, 8'h00, 0); push(1, 8'h02, 0); push(1, 8'h01, 0);
    issue(3'd0, 16'h0102, 24'h030405, 12'd4);
    @(posedge P_clk); #1;
    check("mid_addr_valid", S_Valid, 1'b1);
    check("mid_addr_kind", S_Kind, 2'd1);
    saved = done_cnt;
    P_rst = 1'b1;
    #1;
    check("abort_s_valid", S_Valid, 1'b0);
    check("abort_reqready", H_ReqReady, 1'b1);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge P_clk);
    #1 P_rst = 1'b0;
    repeat (4) @(posedge P_clk); #1;
    check("abort_no_done", done_cnt, saved);

    // New READ completes normally after the abort
    push(0, 8'h00, 0); push(1, 8'h22, 0); push(1, 8'h11, 0);
    push(1, 8'hCC, 0); push(1, 8'hBB, 0); push(1, 8'hAA, 0); push(0, 8'h30, 0);
    push(3, 8'h00, 0); push(3, 8'h00, 1);
    done_q.push_back(1'b0);
    issue(3'd0, 16'h1122, 24'hAABBCC, 12'd2);
    wait_done(200);

    repeat (3) @(posedge P_clk); #1;
    check("final_items_empty", exp_q.size(), 0);
    check("final_done_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
